// File: rtl/game_pkg.sv
// Shared game-screen definitions: keeper FSM state encoding and the keeper's
// legal column range, used by both the keeper controller and the keeper drawer.
package game_pkg;

  localparam int KEEPER_X_W      = 10;
  localparam int KEEPER_X_MIN    = 112;
  localparam int KEEPER_X_MAX    = 612;
  localparam int KEEPER_X_CENTER = 362;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    DIVE   = 3'd2,
    HOLD   = 3'd3,
    RETURN = 3'd4
  } keeper_state_t;

endpackage

// File: rtl/frame_tick.sv
// Registered rising-edge detector on vertical blanking; o_tick is high for the
// single cycle in which vblnk is first sampled high.
module frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic i_vblnk,
  output logic o_tick
);

  logic r_vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) r_vblnk_q <= 1'b0;
    else     r_vblnk_q <= i_vblnk;
  end

  assign o_tick = i_vblnk & ~r_vblnk_q;

endmodule

// File: rtl/keeper_ctl.sv
// Keeper position controller: tracks a target column, performs a scripted dive
// on a shot, holds the pose, then walks back to centre. Moves only on frame ticks.
module keeper_ctl
  import game_pkg::*;
#(
  parameter int X_MIN       = KEEPER_X_MIN,
  parameter int X_MAX       = KEEPER_X_MAX,
  parameter int X_CENTER    = KEEPER_X_CENTER,
  parameter int TRACK_STEP  = 4,
  parameter int DIVE_STEP   = 24,
  parameter int HOLD_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblnk,
  input  logic                  enable,
  input  logic [KEEPER_X_W-1:0] target_x,
  input  logic                  shot,
  input  logic [KEEPER_X_W-1:0] dive_x,
  output logic [KEEPER_X_W-1:0] keeper_x_pos,
  output keeper_state_t         keeper_state,
  output logic                  dive_done
);

  localparam int XW   = KEEPER_X_W;
  localparam int HC_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [XW-1:0] XMIN_C   = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX_C   = XW'(X_MAX);
  localparam logic [XW-1:0] XCEN_C   = XW'(X_CENTER);
  localparam logic [XW:0]   TRACK_C  = (XW+1)'(TRACK_STEP);
  localparam logic [XW:0]   DIVE_C   = (XW+1)'(DIVE_STEP);
  localparam logic [HC_W-1:0] HOLD_INIT_C = HC_W'(HOLD_FRAMES - 1);

  function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] x);
    if (x < XMIN_C)      clamp_x = XMIN_C;
    else if (x > XMAX_C) clamp_x = XMAX_C;
    else                 clamp_x = x;
  endfunction

  // Move pos toward goal by at most step; landing exactly on goal prevents overshoot.
  function automatic logic [XW-1:0] step_toward(input logic [XW-1:0] pos,
                                                input logic [XW-1:0] goal,
                                                input logic [XW:0]   step);
    logic signed [XW:0] d;
    logic signed [XW:0] s;
    d = $signed({1'b0, goal}) - $signed({1'b0, pos});
    s = $signed(step);
    if (d > s)       step_toward = pos + step[XW-1:0];
    else if (d < -s) step_toward = pos - step[XW-1:0];
    else             step_toward = goal;
  endfunction

  logic            w_tick;
  keeper_state_t   r_state, w_state_n;
  logic [XW-1:0]   r_pos, w_pos_n;
  logic [XW-1:0]   r_dive_goal, w_dive_goal_n;
  logic [HC_W-1:0] r_hold_cnt, w_hold_cnt_n;
  logic            r_dive_done, w_dive_done_n;
  logic [XW-1:0]   w_target_c, w_dive_c;
  logic [XW-1:0]   w_track_pos, w_dive_pos, w_ret_pos;

  frame_tick u_frame_tick (
    .clk     (clk),
    .rst     (rst),
    .i_vblnk (vblnk),
    .o_tick  (w_tick)
  );

  assign w_target_c  = clamp_x(target_x);
  assign w_dive_c    = clamp_x(dive_x);
  assign w_track_pos = step_toward(r_pos, w_target_c, TRACK_C);
  assign w_dive_pos  = step_toward(r_pos, r_dive_goal, DIVE_C);
  assign w_ret_pos   = step_toward(r_pos, XCEN_C, TRACK_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pos       <= XCEN_C;
      r_dive_goal <= XCEN_C;
      r_hold_cnt  <= '0;
      r_dive_done <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_pos       <= w_pos_n;
      r_dive_goal <= w_dive_goal_n;
      r_hold_cnt  <= w_hold_cnt_n;
      r_dive_done <= w_dive_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (!enable) begin
      w_state_n = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_n = TRACK;
        TRACK:   if (shot) w_state_n = DIVE;
        DIVE:    if (w_tick && (w_dive_pos == r_dive_goal)) w_state_n = HOLD;
        HOLD:    if (w_tick && (r_hold_cnt == '0)) w_state_n = RETURN;
        RETURN:  if (w_tick && (w_ret_pos == XCEN_C)) w_state_n = TRACK;
        default: w_state_n = IDLE;
      endcase
    end
  end

  // Shot has priority over the tracking step when both land in the same cycle.
  always_comb begin
    w_pos_n       = r_pos;
    w_dive_goal_n = r_dive_goal;
    w_hold_cnt_n  = r_hold_cnt;
    w_dive_done_n = 1'b0;
    if (!enable) begin
      w_pos_n = XCEN_C;
    end else begin
      case (r_state)
        IDLE: w_pos_n = XCEN_C;
        TRACK: begin
          if (shot)        w_dive_goal_n = w_dive_c;
          else if (w_tick) w_pos_n = w_track_pos;
        end
        DIVE: begin
          if (w_tick) begin
            w_pos_n = w_dive_pos;
            if (w_dive_pos == r_dive_goal) w_hold_cnt_n = HOLD_INIT_C;
          end
        end
        HOLD: begin
          if (w_tick) begin
            if (r_hold_cnt == '0) w_dive_done_n = 1'b1;
            else                  w_hold_cnt_n  = r_hold_cnt - 1'b1;
          end
        end
        RETURN:  if (w_tick) w_pos_n = w_ret_pos;
        default: w_pos_n = XCEN_C;
      endcase
    end
  end

  assign keeper_x_pos = r_pos;
  assign keeper_state = r_state;
  assign dive_done    = r_dive_done;

endmodule

// File: tb/tb_keeper_ctl.sv
// Scoreboard bench for keeper_ctl: expected (pos, state, dive_done) tuples are
// queued as stimulus is applied and compared once the DUT has responded.
module tb_keeper_ctl;
  import game_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vblnk = 1'b0;
  logic          enable = 1'b0;
  logic [9:0]    target_x = 10'd362;
  logic          shot = 1'b0;
  logic [9:0]    dive_x = 10'd0;
  logic [9:0]    keeper_x_pos;
  keeper_state_t keeper_state;
  logic          dive_done;

  typedef struct {
    int   pos;
    int   st;
    logic dn;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  keeper_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .vblnk        (vblnk),
    .enable       (enable),
    .target_x     (target_x),
    .shot         (shot),
    .dive_x       (dive_x),
    .keeper_x_pos (keeper_x_pos),
    .keeper_state (keeper_state),
    .dive_done    (dive_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic sb_push(input int pos, input keeper_state_t st, input logic dn);
    exp_t e;
    e.pos = pos;
    e.st  = int'(st);
    e.dn  = dn;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pos"},   32'(keeper_x_pos), 32'(e.pos));
      chk({tag, "_state"}, 32'(keeper_state), 32'(e.st));
      chk({tag, "_done"},  32'(dive_done),    32'(e.dn));
    end
  endtask

  // One clock without a frame tick.
  task automatic expect_clk(input string tag, input int pos, input keeper_state_t st,
                            input logic dn);
    sb_push(pos, st, dn);
    @(posedge clk); #1;
    sb_check(tag);
  endtask

  // One full frame: vblnk high 2 cycles, low 2 cycles; optional shot on the tick cycle.
  task automatic do_tick(input string tag, input logic sh, input int pos,
                         input keeper_state_t st, input logic dn);
    sb_push(pos, st, dn);
    vblnk = 1'b1;
    shot  = sh;
    @(posedge clk); #1;
    shot = 1'b0;
    sb_check(tag);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, 32'(dive_done), 32'd0);
    vblnk = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk); #1;
    expect_clk("reset", 362, IDLE, 1'b0);
    rst = 1'b0;
    expect_clk("idle_disabled", 362, IDLE, 1'b0);
    enable = 1'b1;
    expect_clk("enable", 362, TRACK, 1'b0);

    for (int i = 0; i < 5; i++) do_tick("track_still", 1'b0, 362, TRACK, 1'b0);

    target_x = 10'd380;
    for (int i = 1; i <= 4; i++) do_tick("track_up", 1'b0, 362 + 4 * i, TRACK, 1'b0);
    do_tick("track_land", 1'b0, 380, TRACK, 1'b0);
    do_tick("track_settled", 1'b0, 380, TRACK, 1'b0);

    target_x = 10'd362;
    for (int i = 1; i <= 4; i++) do_tick("track_down", 1'b0, 380 - 4 * i, TRACK, 1'b0);
    do_tick("track_home", 1'b0, 362, TRACK, 1'b0);

    // Dive to a clamped goal of 612.
    dive_x = 10'd900;
    shot   = 1'b1;
    expect_clk("shot", 362, DIVE, 1'b0);
    shot = 1'b0;
    for (int k = 1; k <= 10; k++) do_tick("dive", 1'b0, 362 + 24 * k, DIVE, 1'b0);
    do_tick("dive_land", 1'b0, 612, HOLD, 1'b0);

    for (int k = 1; k <= 29; k++) begin
      do_tick("hold", 1'b0, 612, HOLD, 1'b0);
      if (k == 10) begin
        dive_x = 10'd112;
        shot   = 1'b1;
        expect_clk("hold_shot_ignored", 612, HOLD, 1'b0);
        shot = 1'b0;
      end
    end
    do_tick("hold_exit", 1'b0, 612, RETURN, 1'b1);

    for (int k = 1; k <= 62; k++) do_tick("return", 1'b0, 612 - 4 * k, RETURN, 1'b0);
    do_tick("return_home", 1'b0, 362, TRACK, 1'b0);

    // Shot on the tick cycle: no tracking step, dive toward clamped 112.
    target_x = 10'd380;
    dive_x   = 10'd100;
    do_tick("shot_on_tick", 1'b1, 362, DIVE, 1'b0);
    do_tick("dive_left", 1'b0, 338, DIVE, 1'b0);

    enable = 1'b0;
    shot   = 1'b1;
    expect_clk("disable_mid_dive", 362, IDLE, 1'b0);
    shot = 1'b0;
    expect_clk("disabled_stays", 362, IDLE, 1'b0);
    enable = 1'b1;
    expect_clk("reenable", 362, TRACK, 1'b0);

    // vblnk held high for 100 cycles gives exactly one step.
    vblnk = 1'b1;
    expect_clk("long_vblnk_first", 366, TRACK, 1'b0);
    sb_push(366, TRACK, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    sb_check("long_vblnk_end");
    vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Dive to the current position lands on the first tick.
    dive_x = 10'd366;
    shot   = 1'b1;
    expect_clk("shot_same_pos", 366, DIVE, 1'b0);
    shot = 1'b0;
    do_tick("dive_zero", 1'b0, 366, HOLD, 1'b0);
    for (int k = 0; k < 3; k++) do_tick("hold_b", 1'b0, 366, HOLD, 1'b0);

    rst = 1'b1;
    expect_clk("reset_in_hold", 362, IDLE, 1'b0);
    rst = 1'b0;
    expect_clk("after_reset", 362, TRACK, 1'b0);

    target_x = 10'd0;
    do_tick("target_clamp_lo", 1'b0, 358, TRACK, 1'b0);
    target_x = 10'd1000;
    do_tick("target_clamp_hi", 1'b0, 362, TRACK, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keeper_ctl.md
# keeper_ctl

Per-frame keeper position controller: sequences the `keeper_x_pos` input of the keeper drawing stage. It tracks a target column while the game is live and executes a scripted dive when a shot is taken. It then holds the dive pose and returns the keeper to centre. Updates happen only at frame boundaries (rising edge of vertical blanking), so the drawer never sees the keeper move mid-frame.

## Interface
Parameters:
- `X_MIN`, 112: leftmost legal `keeper_x_pos`.
- `X_MAX`, 612: rightmost legal `keeper_x_pos` (1024 − 300 − 112).
- `X_CENTER`, 362: home/reset position.
- `TRACK_STEP`, 4: max pixels per frame in TRACK and RETURN.
- `DIVE_STEP`, 24: max pixels per frame in DIVE.
- `HOLD_FRAMES`, 30: frames spent in HOLD.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `vblnk`  in  1  vertical blank from the timing chain; its rising edge is the frame tick.
- `enable`  in  1  game live; low forces IDLE.
- `target_x`  in  10  tracking target column.
- `shot`  in  1  single-cycle pulse: shot taken.
- `dive_x`  in  10  dive destination column, sampled with `shot`.
- `keeper_x_pos`  out  10  keeper left edge, to the drawer.
- `keeper_state`  out  3  current state (`keeper_state_t`).
- `dive_done`  out  1  single-cycle pulse on HOLD→RETURN.

## Operation
- Frame tick `tick` = `vblnk` & ~`vblnk_q`, where `vblnk_q` is registered `vblnk`.
- Step rule (all states that move): `d` = goal − pos, 11-bit signed; pos += clamp(`d`, −STEP, +STEP). This never overshoots.
- `target_x` and `dive_x` are clamped to [`X_MIN`, `X_MAX`] before use. `keeper_x_pos` therefore never leaves that range.
- States:
  - **IDLE**: pos = `X_CENTER`. Goes to TRACK when `enable`=1.
  - **TRACK**: on each tick, step toward clamped `target_x` with `TRACK_STEP`. On `shot`=1, latch clamped `dive_x` into `dive_goal` and go to DIVE.
  - **DIVE**: on each tick, step toward `dive_goal` with `DIVE_STEP`. The tick on which pos equals `dive_goal` after the step → HOLD, with `hold_cnt` = `HOLD_FRAMES` − 1.
  - **HOLD**: pos frozen. Each tick decrements `hold_cnt`. A tick with `hold_cnt`=0 → RETURN and pulses `dive_done`.
  - **RETURN**: on each tick, step toward `X_CENTER` with `TRACK_STEP`. On reaching it → TRACK.
- `enable`=0 in any state: next clock goes to IDLE and pos = `X_CENTER`. This overrides everything, including `shot`.
- `shot` outside TRACK is ignored, with no queueing.
- `shot` and `tick` in the same cycle in TRACK: the shot wins. Go to DIVE with no tracking step that frame.
- If `dive_x` equals the current pos: DIVE → HOLD on the first tick.

## Timing
- Reset values: `keeper_x_pos` = `X_CENTER`, `keeper_state` = IDLE, `dive_done` = 0, `vblnk_q` = 0, `hold_cnt` = 0, `dive_goal` = `X_CENTER`.
- Suppose `vblnk` is first sampled high at edge N (`vblnk_q`=1 after N). Then `keeper_x_pos` and state update at edge N. At most one step per frame.
- `dive_done` is high for exactly one cycle, the cycle after the tick edge.
- `shot` → `keeper_state` = DIVE after 1 clk. Position first moves on the next tick.
- Reset mid-dive returns every output to its reset values on the next edge.
- All outputs are registered.

## Structure
- `game_pkg`: `keeper_state_t` (IDLE, TRACK, DIVE, HOLD, RETURN; 3-bit enum), plus shared `KEEPER_X_MIN`/`MAX`/`CENTER` constants used by both this block and `draw_keeper`.
- One sub-module, `frame_tick`: registered rising-edge detector on `vblnk`. It is reusable by the ball controller.
- The step/clamp logic is a local function, not a module.

## Test plan
- Reset, then `enable`=1 with `target_x`=362 → state TRACK, pos stays 362 across 5 ticks.
- TRACK with `target_x`=380 from pos 362 → pos goes 366, 370, 374, 378, 380 on successive ticks, then holds.
- `shot` with `dive_x`=900 from pos 362 → `dive_goal`=612. Pos goes 386 … 602, 612 over 11 ticks, then HOLD. After 30 ticks `dive_done` pulses once, then RETURN at 4 px/frame back to 362, then TRACK.
- `shot` coincident with a tick in TRACK → DIVE, no tracking step. A second `shot` during HOLD is ignored.
- `enable` dropped mid-DIVE → next clk state IDLE, pos 362, no `dive_done`.
- `vblnk` held high for 100 cycles → exactly one step. `rst` pulse in HOLD → all reset values.
